// File: rtl/ptl_tx_pkg.sv
// Shared types and constants for the PTL transmit framer.
package ptl_tx_pkg;

  localparam int unsigned GAP_CW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_t;

  // Accept-to-accept period with din_valid held high.
  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned parity,
                                            input int unsigned gap);
    return 2 + width + parity + gap;
  endfunction

endpackage

// File: rtl/ptl_tx_shift.sv
// Payload shift register, emitted-bit counter and latched even parity.
module ptl_tx_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             shift,
  output logic             bit0,
  output logic             parity,
  output logic             last_bit
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par;

  // cnt counts bits already handed to the output flop, so it reaches WIDTH on the last data slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else if (load) begin
      shreg <= din;
      cnt   <= '0;
      par   <= ^din;
    end else if (shift) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  assign bit0     = shreg[0];
  assign parity   = par;
  assign last_bit = (cnt == CW'(WIDTH));

endmodule

// File: rtl/ptl_tx_framer.sv
// Framed SFQ pulse-train transmitter: start, LSB-first data, optional even parity, idle gap.
module ptl_tx_framer
  import ptl_tx_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PARITY = 1,
  parameter int unsigned GAP    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             busy,
  output logic             frame_done
);

  state_t            state, next;
  logic [GAP_CW-1:0] gcnt;
  logic              load, shift, bit0, parity, last_bit;
  logic              nx_dout;

  ptl_tx_shift #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .load     (load),
    .shift    (shift),
    .bit0     (bit0),
    .parity   (parity),
    .last_bit (last_bit)
  );

  always_comb begin
    next    = state;
    load    = 1'b0;
    nx_dout = 1'b0;
    unique case (state)
      ST_IDLE:  if (din_valid) begin
                  load = 1'b1;
                  next = ST_START;
                end
      ST_START: next = ST_DATA;
      ST_DATA:  if (last_bit) next = (PARITY != 0) ? ST_PAR : ST_GAP;
      ST_PAR:   next = ST_GAP;
      ST_GAP:   if (gcnt == GAP_CW'(GAP)) next = ST_IDLE;
      default:  next = ST_IDLE;
    endcase
    shift = (next == ST_DATA);
    // Outputs are decoded from the next state so each flop shows the slot the FSM has just entered.
    unique case (next)
      ST_START: nx_dout = 1'b1;
      ST_DATA:  nx_dout = bit0;
      ST_PAR:   nx_dout = parity;
      default:  nx_dout = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gcnt       <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      din_ready  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= next;
      if (next == ST_GAP) gcnt <= (state == ST_GAP) ? gcnt + 1'b1 : GAP_CW'(1);
      dout       <= nx_dout;
      busy       <= (next != ST_IDLE);
      din_ready  <= (next == ST_IDLE);
      frame_done <= (state == ST_GAP) && (next == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ptl_tx_framer.sv
// Directed bench for ptl_tx_framer: default instance plus a PARITY=0/GAP=1 instance.
module tb_ptl_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       valid_a [2];
  logic       dout_a  [2];
  logic       busy_a  [2];
  logic       ready_a [2];
  logic       done_a  [2];

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  ptl_tx_framer #(.WIDTH(8), .PARITY(1), .GAP(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(valid_a[0]), .din_ready(ready_a[0]),
    .dout(dout_a[0]), .busy(busy_a[0]), .frame_done(done_a[0])
  );

  ptl_tx_framer #(.WIDTH(8), .PARITY(0), .GAP(1)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(valid_a[1]), .din_ready(ready_a[1]),
    .dout(dout_a[1]), .busy(busy_a[1]), .frame_done(done_a[1])
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int s, input string tag);
    chk({tag, " dout"},  dout_a[s],  1'b0);
    chk({tag, " busy"},  busy_a[s],  1'b0);
    chk({tag, " ready"}, ready_a[s], 1'b1);
    chk({tag, " done"},  done_a[s],  1'b0);
  endtask

  // Present a word and pass the accept edge; returns #1 into cycle T+1.
  task automatic accept(input int s, input logic [7:0] d, input logic hold);
    din        = d;
    valid_a[s] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid_a[s] = 1'b0;
  endtask

  // pat[k] is the expected pulse in cycle T+k; L is the period, cycle T+L is the first IDLE.
  task automatic check_frame(input int s, input logic [15:0] pat, input int L,
                             input logic toggle, input string tag);
    for (int k = 1; k <= L; k++) begin
      chk($sformatf("%s dout T+%0d", tag, k),  dout_a[s],  pat[k]);
      chk($sformatf("%s busy T+%0d", tag, k),  busy_a[s],  k < L);
      chk($sformatf("%s ready T+%0d", tag, k), ready_a[s], k == L);
      chk($sformatf("%s done T+%0d", tag, k),  done_a[s],  k == L);
      if (toggle && k < L) begin
        valid_a[s] = (k < L - 1) ? k[0] : 1'b0;
        din        = 8'($urandom);
      end
      if (k < L) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    valid_a[0] = 1'b0;
    valid_a[1] = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk_quiet(0, "reset0");
    chk_quiet(1, "reset1");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet(0, "idle0");

    accept(0, 8'hA5, 1'b0);
    check_frame(0, 16'h0296, 13, 1'b0, "a5");

    accept(0, 8'h07, 1'b0);
    check_frame(0, 16'h041E, 13, 1'b0, "07");

    accept(0, 8'h00, 1'b0);
    check_frame(0, 16'h0002, 13, 1'b0, "00");

    accept(0, 8'h00, 1'b0);
    check_frame(0, 16'h0002, 13, 1'b1, "toggle");
    @(posedge clk);
    #1;
    chk_quiet(0, "after_toggle");

    // Continuous valid: the second word is accepted on the first IDLE edge.
    accept(0, 8'hFF, 1'b1);
    din = 8'h01;
    check_frame(0, 16'h03FE, 13, 1'b0, "ff");
    @(posedge clk);
    #1;
    valid_a[0] = 1'b0;
    check_frame(0, 16'h0406, 13, 1'b0, "b2b01");

    accept(0, 8'hFF, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("midframe dout T+5", dout_a[0], 1'b1);
    chk("midframe busy T+5", busy_a[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_quiet(0, "async_rst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst done c%0d", i), done_a[0], 1'b0);
      chk($sformatf("post_rst dout c%0d", i), dout_a[0], 1'b0);
    end
    accept(0, 8'h01, 1'b0);
    check_frame(0, 16'h0406, 13, 1'b0, "after_rst01");

    accept(1, 8'h80, 1'b0);
    check_frame(1, 16'h0202, 11, 1'b0, "p0g1_80");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
